// File: rtl/pp_buffer_pkg.sv
// pp_buffer_pkg: sizing helpers so producers, consumers and the buffer derive identical port widths
package pp_buffer_pkg;
    function automatic int calc_word_w(input int width, input int cores_a, input int cores_b);
        return width * top_pkg::TOP_CHUNK_SIZE * cores_a * cores_b;
    endfunction
    function automatic int calc_depth(input int col_x, input int total_input_w);
        return col_x * total_input_w;
    endfunction
    function automatic int calc_bank_w(input int num_banks);
        return num_banks > 2 ? $clog2(num_banks) : 1;
    endfunction
endpackage

// File: rtl/top_pkg.sv
// top_pkg: project-wide constants shared by all attention datapath blocks
package top_pkg;
    localparam int TOP_CHUNK_SIZE = 4;
endpackage

// File: rtl/pp_sdp_ram.sv
// pp_sdp_ram: simple dual-port RAM of NUM_BANKS*DEPTH words with a 1-cycle registered read
// Ports: clk, rst (clears only the read register), we/wr_bank/wr_addr/wr_data write port,
//        re/rd_bank/rd_addr read port, rd_data registered read word (held while re=0).
module pp_sdp_ram
    import pp_buffer_pkg::*;
#(
    parameter int WORD_W    = 128,
    parameter int DEPTH     = 32,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BANK_W    = calc_bank_w(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              re,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    localparam int RAM_AW = $clog2(NUM_BANKS * DEPTH);
    logic [WORD_W-1:0] mem [NUM_BANKS*DEPTH];
    logic [RAM_AW-1:0] wa, ra;
    // bank*DEPTH+addr keeps the array dense when NUM_BANKS is not a power of two
    always_comb begin
        wa = RAM_AW'(wr_bank) * RAM_AW'(DEPTH) + RAM_AW'(wr_addr);
        ra = RAM_AW'(rd_bank) * RAM_AW'(DEPTH) + RAM_AW'(rd_addr);
    end
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wr_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else if (re) rd_data <= mem[ra];
    end
endmodule

// File: rtl/multi_bank_pingpong_buffer.sv
// multi_bank_pingpong_buffer: N-bank fill/commit/release buffer between a streaming producer and a random-access consumer
// Ports: clk, rst (async, active-high);
//        producer: wr_valid, wr_ready, wr_data;
//        consumer: rd_bank_valid, rd_req, rd_addr, rd_valid, rd_data, rd_release;
//        status: active_bank_wr, active_bank_rd, full_count, err_release (sticky).
module multi_bank_pingpong_buffer
    import pp_buffer_pkg::*;
#(
    parameter  int WIDTH         = 16,
    parameter  int NUM_CORES_A   = 2,
    parameter  int NUM_CORES_B   = 1,
    parameter  int COL_X         = 16,
    parameter  int TOTAL_INPUT_W = 2,
    parameter  int NUM_BANKS     = 2,
    localparam int WORD_W        = calc_word_w(WIDTH, NUM_CORES_A, NUM_CORES_B),
    localparam int DEPTH         = calc_depth(COL_X, TOTAL_INPUT_W),
    localparam int ADDR_W        = $clog2(DEPTH),
    localparam int BANK_W        = calc_bank_w(NUM_BANKS),
    localparam int CNT_W         = $clog2(NUM_BANKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_bank_valid,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    input  logic              rd_release,
    output logic [BANK_W-1:0] active_bank_wr,
    output logic [BANK_W-1:0] active_bank_rd,
    output logic [CNT_W-1:0]  full_count,
    output logic              err_release
);
    logic [BANK_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept, commit, release_ok, rd_fire;
    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return b == BANK_W'(NUM_BANKS - 1) ? '0 : b + BANK_W'(1);
    endfunction
    // The writer stalls once every bank is committed, so the bank being filled
    // can never alias the bank being read.
    always_comb begin
        wr_ready       = full_count < CNT_W'(NUM_BANKS);
        rd_bank_valid  = full_count != '0;
        accept         = wr_valid && wr_ready;
        commit         = accept && wr_addr == ADDR_W'(DEPTH - 1);
        release_ok     = rd_release && rd_bank_valid;
        rd_fire        = rd_req && rd_bank_valid;
        active_bank_wr = wr_ptr;
        active_bank_rd = rd_ptr;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_addr     <= '0;
            full_count  <= '0;
            rd_valid    <= 1'b0;
            err_release <= 1'b0;
        end else begin
            if (accept) wr_addr <= commit ? '0 : wr_addr + ADDR_W'(1);
            if (commit) wr_ptr <= next_bank(wr_ptr);
            if (release_ok) rd_ptr <= next_bank(rd_ptr);
            // simultaneous commit and release leaves the count unchanged
            if (commit != release_ok) full_count <= commit ? full_count + CNT_W'(1) : full_count - CNT_W'(1);
            if (rd_release && !rd_bank_valid) err_release <= 1'b1;
            rd_valid <= rd_fire;
        end
    end
    pp_sdp_ram #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W), .BANK_W(BANK_W)
    ) u_ram (
        .clk(clk), .rst(rst),
        .we(accept), .wr_bank(wr_ptr), .wr_addr(wr_addr), .wr_data(wr_data),
        .re(rd_fire), .rd_bank(rd_ptr), .rd_addr(rd_addr), .rd_data(rd_data)
    );
endmodule

// File: tb/tb_multi_bank_pingpong_buffer.sv
// tb_multi_bank_pingpong_buffer: 2-bank and 3-bank instances driven in lockstep, scoreboarded against a queue-level model
module tb_multi_bank_pingpong_buffer;
    import pp_buffer_pkg::*;
    localparam int D = calc_depth(16, 2);
    localparam int W = calc_word_w(16, 2, 1);

    logic clk = 1'b0, rst = 1'b0, wr_valid = 1'b0, rd_req = 1'b0, rd_release = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [4:0] rd_addr = '0;

    logic wr_ready2, bv2, rv2, err2, wr_ready3, bv3, rv3, err3;
    logic [W-1:0] rdat2, rdat3;
    logic [1:0] fc2, fc3, abw3, abr3;
    logic [0:0] abw2, abr2;

    multi_bank_pingpong_buffer #(.NUM_BANKS(2)) dut2 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_data(wr_data),
        .rd_bank_valid(bv2), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rv2), .rd_data(rdat2),
        .rd_release(rd_release), .active_bank_wr(abw2), .active_bank_rd(abr2),
        .full_count(fc2), .err_release(err2));
    multi_bank_pingpong_buffer #(.NUM_BANKS(3)) dut3 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_data(wr_data),
        .rd_bank_valid(bv3), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rv3), .rd_data(rdat3),
        .rd_release(rd_release), .active_bank_wr(abw3), .active_bank_rd(abr3),
        .full_count(fc3), .err_release(err3));

    always #5 clk = ~clk;

    int m_cnt[2], m_wb[2], m_wa[2], m_rb[2];
    bit m_err[2], m_rv[2];
    logic [W-1:0] mem[2][3*D];
    logic [W-1:0] exp_q[2][$];
    int rd_idx[2];
    logic [W-1:0] last[2];
    bit armed = 0;
    int n_chk = 0, n_err = 0;

    // reference model: a bank is either being filled, committed (queued for the reader) or free
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int nb;
            bit acc, com, rel;
            nb = (i == 0) ? 2 : 3;
            if (rst) begin
                m_cnt[i] = 0; m_wb[i] = 0; m_wa[i] = 0; m_rb[i] = 0; m_err[i] = 0; m_rv[i] = 0;
            end else begin
                m_rv[i] = rd_req && m_cnt[i] != 0;
                if (m_rv[i]) exp_q[i].push_back(mem[i][m_rb[i] * D + int'(rd_addr)]);
                acc = wr_valid && m_cnt[i] < nb;
                com = acc && m_wa[i] == D - 1;
                rel = rd_release && m_cnt[i] != 0;
                if (acc) begin
                    mem[i][m_wb[i] * D + m_wa[i]] = wr_data;
                    m_wa[i] = (m_wa[i] + 1) % D;
                end
                if (com) m_wb[i] = (m_wb[i] + 1) % nb;
                if (rd_release && m_cnt[i] == 0) m_err[i] = 1;
                if (rel) m_rb[i] = (m_rb[i] + 1) % nb;
                m_cnt[i] = m_cnt[i] + int'(com) - int'(rel);
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [W-1:0] a, input logic [W-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            armed = 1;
            last[0] = '0;
            last[1] = '0;
        end else if (armed) begin
            for (int i = 0; i < 2; i++) begin
                logic a_rdy, a_bv, a_rv, a_err;
                logic [W-1:0] a_dat;
                int a_fc, a_bw, a_br, nb;
                nb    = (i == 0) ? 2 : 3;
                a_rdy = (i == 0) ? wr_ready2 : wr_ready3;
                a_bv  = (i == 0) ? bv2 : bv3;
                a_rv  = (i == 0) ? rv2 : rv3;
                a_err = (i == 0) ? err2 : err3;
                a_dat = (i == 0) ? rdat2 : rdat3;
                a_fc  = (i == 0) ? int'(fc2) : int'(fc3);
                a_bw  = (i == 0) ? int'(abw2) : int'(abw3);
                a_br  = (i == 0) ? int'(abr2) : int'(abr3);
                chk("wr_ready", i, W'(a_rdy), W'(m_cnt[i] < nb));
                chk("rd_bank_valid", i, W'(a_bv), W'(m_cnt[i] != 0));
                chk("full_count", i, W'(a_fc), W'(m_cnt[i]));
                chk("active_bank_wr", i, W'(a_bw), W'(m_wb[i]));
                chk("active_bank_rd", i, W'(a_br), W'(m_rb[i]));
                chk("err_release", i, W'(a_err), W'(m_err[i]));
                chk("rd_valid", i, W'(a_rv), W'(m_rv[i]));
                if (a_rv) begin
                    if (rd_idx[i] < exp_q[i].size()) begin
                        chk("rd_data", i, a_dat, exp_q[i][rd_idx[i]]);
                        last[i] = exp_q[i][rd_idx[i]];
                        rd_idx[i]++;
                    end else begin
                        n_chk++;
                        n_err++;
                        $display("FAIL rd_unexpected dut%0d: got rd_valid=1 expected no pending read", i);
                    end
                end else chk("rd_hold", i, a_dat, last[i]);
            end
        end
    end

    task automatic cyc(input bit wv, input logic [W-1:0] wd, input bit rq, input int ra, input bit rl);
        @(negedge clk);
        #1;
        wr_valid = wv; wr_data = wd; rd_req = rq; rd_addr = 5'(ra); rd_release = rl;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst = 1; wr_valid = 0; rd_req = 0; rd_release = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        do_reset(3);
        for (int i = 0; i < 32; i++) cyc(1, W'(i), 0, 0, 0);
        cyc(0, '0, 1, 5, 0);
        cyc(0, '0, 0, 0, 0);
        for (int i = 0; i < 70; i++) cyc(1, W'(100 + i), 0, 0, 0);
        cyc(0, '0, 1, 7, 1);
        cyc(0, '0, 1, 9, 0);
        cyc(0, '0, 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 32; i++) cyc(1, W'(200 + i), 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 31; i++) cyc(1, W'(300 + 32 * r + i), i == 3, i, 0);
            cyc(1, W'(300 + 32 * r + 31), 1, 30 - r, 1);
        end
        cyc(0, '0, 0, 0, 0);
        do_reset(1);
        cyc(0, '0, 1, 3, 1);
        cyc(0, '0, 1, 3, 1);
        cyc(0, '0, 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 10; i++) cyc(1, W'(400 + i), 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 32; i++) cyc(1, W'(500 + i), 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 31, 0);
        for (int k = 0; k < 3000; k++) begin
            logic [W-1:0] d;
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                $urandom_range(0, 39) == 0);
        end
        cyc(0, '0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
